// File: rtl/pulse_pkg.sv
// pulse_pkg: shared FSM state type and default sizing for the pulse measurement blocks.
package pulse_pkg;
  typedef enum logic {ST_LOW, ST_HIGH} state_e;
  localparam int PULSE_W = 16;
  localparam int PULSE_SYNC = 2;
endpackage

// File: rtl/pulse_meter_if.sv
// pulse_meter_if: measurement result port, valid/ready handshake; master produces results.
interface pulse_meter_if
  import pulse_pkg::*;
#(
  parameter int W = PULSE_W
);
  logic [W-1:0] gap;
  logic [W-1:0] len;
  logic         gap_ovf;
  logic         len_ovf;
  logic         overrun;
  logic         valid;
  logic         ready;
  modport master (output gap, len, gap_ovf, len_ovf, overrun, valid, input ready);
  modport slave (input gap, len, gap_ovf, len_ovf, overrun, valid, output ready);
endinterface

// File: rtl/pulse_sync.sv
// pulse_sync: SYNC-stage flop chain bringing an asynchronous level into the clk domain.
module pulse_sync
  import pulse_pkg::*;
#(
  parameter int SYNC = PULSE_SYNC
) (
  input  logic clk,
  input  logic rstn,
  input  logic d_i,
  output logic q_o
);
  logic [SYNC-1:0] sync_q;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) sync_q <= '0;
    else sync_q <= {sync_q[SYNC-2:0], d_i};
  assign q_o = sync_q[SYNC-1];
endmodule

// File: rtl/pulse_meter.sv
// pulse_meter: measures low gap and high length of each pulse on an async line, result on valid/ready.
// Define PULSE_METER_FILTER_EN to fold pulses shorter than MIN_LEN back into the gap.
module pulse_meter
  import pulse_pkg::*;
#(
  parameter int W       = PULSE_W,
  parameter int SYNC    = PULSE_SYNC,
  parameter int MIN_LEN = 2
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          pulse_in,
  pulse_meter_if.master res
);
`ifdef PULSE_METER_FILTER_EN
  localparam bit FILTER = 1'b1;
`else
  localparam bit FILTER = 1'b0;
`endif
  localparam logic [W-1:0] MAX = '1;
  localparam logic [W-1:0] MIN_V = W'(MIN_LEN);
  logic         s;
  state_e       state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d, gap_q, gap_d, inc, merged;
  logic [W+1:0] merge_sum;
  logic         gap_ovf_q, gap_ovf_d, sat, glitch, publish;
  logic [W-1:0] rgap_q, rgap_d, rlen_q, rlen_d;
  logic         rgovf_q, rgovf_d, rlovf_q, rlovf_d;
  logic         valid_q, valid_d, overrun_q, overrun_d;

  pulse_sync #(.SYNC(SYNC)) u_sync (.clk(clk), .rstn(rstn), .d_i(pulse_in), .q_o(s));

  assign sat = cnt_q == MAX;
  assign inc = sat ? cnt_q : cnt_q + 1'b1;
  // A filtered glitch rejoins the gap: earlier gap + glitch cycles + this low sample.
  assign merge_sum = {2'b0, gap_q} + {2'b0, cnt_q} + (W+2)'(1);
  assign merged = |merge_sum[W+1:W] ? MAX : merge_sum[W-1:0];
  assign glitch = FILTER && (cnt_q < MIN_V);

  always_comb begin
    state_d = state_q;
    cnt_d = inc;
    gap_d = gap_q;
    gap_ovf_d = gap_ovf_q;
    publish = 1'b0;
    if (state_q == ST_LOW) begin
      if (s) begin
        gap_d = cnt_q;
        gap_ovf_d = sat;
        cnt_d = W'(1);
        state_d = ST_HIGH;
      end
    end else if (!s) begin
      publish = !glitch;
      cnt_d = glitch ? merged : W'(1);
      state_d = ST_LOW;
    end
  end

  always_comb begin
    rgap_d = publish ? gap_q : rgap_q;
    rlen_d = publish ? cnt_q : rlen_q;
    rgovf_d = publish ? gap_ovf_q : rgovf_q;
    rlovf_d = publish ? sat : rlovf_q;
    valid_d = publish || (valid_q && !res.ready);
    overrun_d = publish ? (valid_q && !res.ready) : (overrun_q && !res.ready);
  end

  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state_q <= ST_LOW;
      cnt_q <= '0;
      gap_q <= '0;
      gap_ovf_q <= 1'b0;
      rgap_q <= '0;
      rlen_q <= '0;
      rgovf_q <= 1'b0;
      rlovf_q <= 1'b0;
      valid_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      gap_q <= gap_d;
      gap_ovf_q <= gap_ovf_d;
      rgap_q <= rgap_d;
      rlen_q <= rlen_d;
      rgovf_q <= rgovf_d;
      rlovf_q <= rlovf_d;
      valid_q <= valid_d;
      overrun_q <= overrun_d;
    end

  assign res.gap = rgap_q;
  assign res.len = rlen_q;
  assign res.gap_ovf = rgovf_q;
  assign res.len_ovf = rlovf_q;
  assign res.valid = valid_q;
  assign res.overrun = overrun_q;
endmodule

// File: tb/tb_pulse_meter.sv
// tb_pulse_meter: table vectors, corner sequences and random runs against a run-length reference model.
module tb_pulse_meter;
  import pulse_pkg::*;
  localparam int SYNC = PULSE_SYNC;
  localparam int MIN_LEN = 2;
  localparam int F = SYNC + 2;
`ifdef PULSE_METER_FILTER_EN
  localparam bit FILTER = 1'b1;
`else
  localparam bit FILTER = 1'b0;
`endif

  typedef struct {int lead; int high; int gap; int len;} vec_t;
  typedef struct {int gap; int len;} res_t;

  logic clk = 1'b0, rstn = 1'b0, pulse_in = 1'b0, ready = 1'b0;
  always #5 clk = ~clk;

  pulse_meter_if #(.W(16)) ifa ();
  pulse_meter_if #(.W(4)) ifb ();
  assign ifa.ready = ready;
  assign ifb.ready = ready;

  pulse_meter #(.W(16), .SYNC(SYNC), .MIN_LEN(MIN_LEN)) dut_a (
    .clk(clk), .rstn(rstn), .pulse_in(pulse_in), .res(ifa.master));
  pulse_meter #(.W(4), .SYNC(SYNC), .MIN_LEN(MIN_LEN)) dut_b (
    .clk(clk), .rstn(rstn), .pulse_in(pulse_in), .res(ifb.master));

  int total = 0, bad = 0;
  logic [SYNC-1:0] pipe;
  bit   in_high, ev, eo;
  int   low_run, high_run, gap_run, eg, el;
  res_t rq[$];
  res_t want[$];
  res_t r0;
  vec_t tbl[5];

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    pipe = '0;
    in_high = 0;
    low_run = 0;
    high_run = 0;
    gap_run = 0;
    eg = 0;
    el = 0;
    ev = 0;
    eo = 0;
  endtask

  // Unbounded run lengths; saturation is applied only when forming expected outputs.
  task automatic model_edge(input bit p, input bit r);
    bit s, pub;
    s = pipe[SYNC-1];
    pub = 0;
    if (!in_high) begin
      if (s) begin gap_run = low_run; high_run = 1; in_high = 1; end
      else low_run++;
    end else if (s) high_run++;
    else begin
      in_high = 0;
      if (FILTER && high_run < MIN_LEN) low_run = gap_run + high_run + 1;
      else begin pub = 1; low_run = 1; end
    end
    if (pub) begin
      eo = ev && !r;
      ev = 1;
      eg = gap_run;
      el = high_run;
    end else if (ev && r) begin
      ev = 0;
      eo = 0;
    end
    pipe = {pipe[SYNC-2:0], p};
  endtask

  function automatic logic [63:0] expv(input int w);
    int m = (1 << w) - 1;
    int g = eg > m ? m : eg;
    int l = el > m ? m : el;
    return 64'({ev, eo, eg >= m, el >= m, 16'(g), 16'(l)});
  endfunction

  function automatic logic [63:0] act_a();
    return 64'({ifa.valid, ifa.overrun, ifa.gap_ovf, ifa.len_ovf, ifa.gap, ifa.len});
  endfunction

  function automatic logic [63:0] act_b();
    return 64'({ifb.valid, ifb.overrun, ifb.gap_ovf, ifb.len_ovf, 12'b0, ifb.gap, 12'b0, ifb.len});
  endfunction

  task automatic step(input bit p, input bit r);
    pulse_in = p;
    ready = r;
    @(posedge clk);
    if (!rstn) model_reset();
    else model_edge(p, r);
    @(negedge clk);
    cmp("cycle_w16", act_a(), expv(16));
    cmp("cycle_w4", act_b(), expv(4));
    if (ifa.valid && r) rq.push_back('{int'(ifa.gap), int'(ifa.len)});
  endtask

  initial begin
    int n;
    bit pv;
    model_reset();
    tbl = '{'{8, 2, 10, 2}, '{1, 7, 5, 7}, '{10, 4, 14, 4}, '{0, 3, 4, 3}, '{30, 2, 34, 2}};
    repeat (3) step(0, 1);
    cmp("reset", act_a(), 64'd0);
    rstn = 1'b1;
    foreach (tbl[i]) begin
      rq.delete();
      repeat (tbl[i].lead) step(0, 1);
      repeat (tbl[i].high) step(1, 1);
      repeat (F) step(0, 1);
      if (rq.size() > 0) r0 = rq[0];
      else r0 = '{-1, -1};
      cmp($sformatf("tbl%0d", i), 64'({16'(rq.size()), 16'(r0.gap), 16'(r0.len)}),
          64'({16'd1, 16'(tbl[i].gap), 16'(tbl[i].len)}));
    end
    // Two results while the consumer stalls.
    repeat (3) step(0, 0);
    repeat (2) step(1, 0);
    repeat (6) step(0, 0);
    repeat (3) step(1, 0);
    repeat (6) step(0, 0);
    cmp("ovr_hold", 64'({ifa.valid, ifa.overrun, ifa.gap, ifa.len}), 64'({2'b11, 16'd6, 16'd3}));
    step(0, 1);
    cmp("ovr_clear", 64'({ifa.valid, ifa.overrun}), 64'd0);
    // Saturation on the narrow instance.
    repeat (20) step(0, 1);
    repeat (20) step(1, 1);
    n = 0;
    while (!ifb.valid && n < 8) begin step(0, 1); n++; end
    cmp("sat_w4", 64'({ifb.valid, ifb.gap_ovf, ifb.len_ovf, ifb.gap, ifb.len}), 64'({3'b111, 4'hf, 4'hf}));
    cmp("sat_w16", 64'({ifa.valid, ifa.gap_ovf, ifa.len_ovf, ifa.gap, ifa.len}), 64'({3'b100, 16'd27, 16'd20}));
    repeat (3) step(0, 1);
    // Async reset with a pending result and a pulse in progress.
    repeat (3) step(0, 0);
    repeat (2) step(1, 0);
    repeat (5) step(0, 0);
    repeat (3) step(1, 0);
    cmp("pending", 64'(ifa.valid), 64'd1);
    #2 rstn = 1'b0;
    #1 cmp("async_rst", act_a(), 64'd0);
    model_reset();
    repeat (2) step(0, 1);
    rstn = 1'b1;
    rq.delete();
    repeat (2) step(0, 1);
    repeat (3) step(1, 1);
    repeat (F) step(0, 1);
    if (rq.size() > 0) r0 = rq[0];
    else r0 = '{-1, -1};
    cmp("rst_rel", 64'({16'(rq.size()), 16'(r0.gap), 16'(r0.len)}), 64'({16'd1, 16'd4, 16'd3}));
    // Pulse already high when reset releases.
    rstn = 1'b0;
    repeat (2) step(1, 1);
    rstn = 1'b1;
    rq.delete();
    repeat (4) step(1, 1);
    repeat (F) step(0, 1);
    if (rq.size() > 0) r0 = rq[0];
    else r0 = '{-1, -1};
    cmp("high_at_rel", 64'({16'(rq.size()), 16'(r0.gap), 16'(r0.len)}), 64'({16'd1, 16'd2, 16'd4}));
    // One-cycle glitch between low runs.
    rq.delete();
    repeat (3) step(1, 1);
    repeat (4) step(0, 1);
    step(1, 1);
    repeat (3) step(0, 1);
    repeat (5) step(1, 1);
    repeat (F) step(0, 1);
`ifdef PULSE_METER_FILTER_EN
    want = '{'{4, 3}, '{8, 5}};
`else
    want = '{'{4, 3}, '{4, 1}, '{3, 5}};
`endif
    cmp("glitch_n", 64'(rq.size()), 64'(want.size()));
    foreach (want[i]) begin
      if (i < rq.size()) r0 = rq[i];
      else r0 = '{-1, -1};
      cmp($sformatf("glitch%0d", i), 64'({16'(r0.gap), 16'(r0.len)}), 64'({16'(want[i].gap), 16'(want[i].len)}));
    end
    // Random runs with a randomly stalling consumer.
    pv = 0;
    repeat (80) begin
      n = $urandom_range(1, 8);
      pv = !pv;
      repeat (n) step(pv, $urandom_range(0, 3) != 0);
    end
    repeat (F) step(0, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pulse_meter.md
Name: pulse_meter

Overview:
- Receive-side counterpart of the team's delayed-pulse generator and clock-crossing pulse logic.
- Samples an asynchronous pulse line into the clk domain, then measures two values for each pulse:
  - the gap: low time before the rising edge, in clk cycles;
  - the length: high time, in clk cycles.
- Delivers each (gap, length) pair on a valid/ready result port.
- Used in benches and on silicon to check generator timing and to decode pulse-width signalling from another clock domain.

Parameters:
- W, 16: width of the gap and length counters and result fields.
- SYNC, 2: number of synchronizer flops on pulse_in; legal values 2..4.
- MIN_LEN, 2: minimum accepted length in cycles; used only when PULSE_METER_FILTER_EN is defined.

Ports:
- clk  in  1  sampling clock.
- rstn  in  1  reset, asynchronous, active-low.
- pulse_in  in  1  asynchronous pulse line; no timing relation to clk.
- gap  out  W  measured low cycles before the rising edge.
- len  out  W  measured high cycles.
- gap_ovf  out  1  the gap counter saturated during this measurement.
- len_ovf  out  1  the length counter saturated during this measurement.
- overrun  out  1  one or more results were overwritten before being accepted.
- valid  out  1  result fields are valid.
- ready  in  1  consumer accepts the result when valid&&ready at a clk edge.

Behaviour:
- Reset and clocking:
  - Reset is asynchronous and active-low (rstn); the clock is clk.
  - Reset values: all synchronizer flops 0, FSM in LOW, counter 0.
  - All outputs reset to 0: gap, len, gap_ovf, len_ovf, overrun, valid.
- Synchronizer:
  - SYNC-flop chain on pulse_in; its output is s.
  - FSM samples s one register later.
- FSM states:
  - LOW:
    - s==0: cnt <= cnt+1 (saturating).
    - s==1: latch gap_r <= cnt and gap_ovf_r <= sat; reset cnt <= 1; go to HIGH.
  - HIGH:
    - s==1: cnt <= cnt+1 (saturating).
    - s==0: publish the result; reset cnt <= 1, counting this low sample as gap cycle 1; go to LOW.
- Counter rules:
  - cnt saturates at 2^W-1 and never wraps.
  - sat is set while cnt == 2^W-1.
  - A pulse stuck high or low forever produces no result and no wrap.
- Latency and numbering:
  - Edge 1 is the first clk edge after rstn releases.
  - First measurement: if pulse_in is first sampled high at edge k and stays high for L edges, then gap = k+SYNC-1 (includes synchronizer latency) and len = L.
  - Later measurements: gap = number of low samples between pulses; synchronizer latency cancels.
  - valid rises in the cycle after the falling edge of s is seen; total latency from the last high input sample is SYNC+1 edges.
- Publish:
  - gap <= gap_r, len <= cnt, gap_ovf <= gap_ovf_r, len_ovf <= sat, valid <= 1.
- Handshake:
  - valid&&ready with no publish in the same cycle: valid <= 0 and overrun <= 0.
  - Result fields hold while valid&&!ready.
- Boundary cases:
  - Publish while valid&&!ready: fields overwritten, overrun <= 1, valid stays 1.
  - Publish in the same cycle as valid&&ready: new result loads, valid stays 1, overrun <= 0.
  - rstn asserted mid-measurement or mid-handshake: everything clears immediately; the pending result is lost.
  - A pulse high at reset release is seen as a rising edge after SYNC+1 edges, giving gap = SYNC.

Optional Feature:
- Macro: PULSE_METER_FILTER_EN.
- Defined:
  - In HIGH on s==0 with cnt < MIN_LEN, the pulse is a glitch: no publish.
  - FSM returns to LOW with cnt <= gap_r + cnt + 1 (saturating); the glitch cycles count as gap.
- Undefined:
  - Every high run of 1 or more cycles is published; MIN_LEN is unused.

Decomposition:
- Shared package pulse_pkg holds:
  - state enum {ST_LOW, ST_HIGH};
  - default constants PULSE_W=16 and PULSE_SYNC=2.
- One sub-module, pulse_sync:
  - parameterized SYNC-stage synchronizer with async active-low reset;
  - reusable by the team's other clock-crossing blocks.

Test Plan:
- Synchronous stimulus: pulse_in high at edges 9..10, ready=1, SYNC=2 -> one result gap=10, len=2, valid for 1 cycle, no flags.
- Two pulses, gap of 5 low edges between them, second len=7 -> second result gap=5, len=7.
- Hold ready=0 through two pulses -> valid stays 1, second result shown, overrun=1; assert ready -> valid=0, overrun=0.
- W=4, pulse_in high 20 cycles -> len=15, len_ovf=1; low 20 cycles before it -> gap=15, gap_ovf=1.
- Assert rstn mid-HIGH, release, pulse high edges 3..5 -> all outputs 0 during reset, then gap=4, len=3.
- PULSE_METER_FILTER_EN with MIN_LEN=2:
  - 1-cycle glitch between 4-low and 3-low runs, then a len=5 pulse -> single result gap=8, len=5;
  - without the macro, the glitch is reported as len=1.
